// File: rtl/stream_drain_pkg.sv
// stream_drain_pkg: shared state encoding and burst-length clamp for the drain burst reader
package stream_drain_pkg;

    localparam int unsigned MAX_BURST_DEFAULT = 16;

    typedef enum logic [2:0] {IDLE, WAIT, REQ, CMD, DATA, DONE} state_t;

    // A request of 0 beats still moves one beat; anything beyond the limit is capped
    function automatic logic [8:0] clamp_burst(input logic [7:0] len, input int unsigned max_burst);
        return (len == 8'd0) ? 9'd1 : ({1'b0, len} > 9'(max_burst)) ? 9'(max_burst) : {1'b0, len};
    endfunction

endpackage

// File: rtl/sram_drain_burst_reader.sv
// sram_drain_burst_reader: splits a transfer into reserved bursts and streams SRAM beats to a W channel
module sram_drain_burst_reader
    import stream_drain_pkg::*;
#(
    parameter int DATA_WIDTH      = 512,
    parameter int SRAM_DEPTH      = 512,
    parameter int SEG_COUNT_WIDTH = $clog2(SRAM_DEPTH) + 1,
    parameter int MAX_BURST       = MAX_BURST_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 cfg_burst_len,
    input  logic                       xfer_start,
    input  logic [31:0]                xfer_beats,
    output logic                       xfer_busy,
    output logic                       xfer_done,
    input  logic [SEG_COUNT_WIDTH-1:0] drain_data_avail,
    output logic                       drain_req,
    output logic [7:0]                 drain_size,
    input  logic                       sram_valid,
    output logic                       sram_ready,
    input  logic [DATA_WIDTH-1:0]      sram_data,
    output logic                       m_burst_valid,
    input  logic                       m_burst_ready,
    output logic [7:0]                 m_burst_len,
    output logic                       m_wvalid,
    input  logic                       m_wready,
    output logic [DATA_WIDTH-1:0]      m_wdata,
    output logic                       m_wlast
);

    state_t      state, state_next;
    logic [31:0] remaining;
    logic [8:0]  beat_cnt, burst_beats, burst_calc, burst_clamp, burst_m1;
    logic        beat_hs, last_beat;

    assign burst_clamp = clamp_burst(cfg_burst_len, MAX_BURST);
    assign burst_calc  = (remaining < 32'(burst_clamp)) ? remaining[8:0] : burst_clamp;
    assign burst_m1    = burst_beats - 9'd1;
    assign beat_hs     = (state == DATA) && sram_valid && m_wready;
    assign last_beat   = beat_cnt == burst_m1;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (xfer_start) state_next = (xfer_beats == 32'd0) ? DONE : WAIT;
            WAIT: if (32'(drain_data_avail) >= 32'(burst_calc)) state_next = REQ;
            REQ:  state_next = CMD;
            CMD:  if (m_burst_ready) state_next = DATA;
            DATA: if (beat_hs && last_beat) state_next = (remaining == 32'(burst_beats)) ? DONE : WAIT;
            default: state_next = IDLE;
        endcase
    end

    // Size is frozen in the last WAIT cycle so the reservation matches the availability check
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remaining   <= '0;
            beat_cnt    <= '0;
            burst_beats <= '0;
        end else begin
            if (state == IDLE && xfer_start) remaining <= xfer_beats;
            if (state == WAIT) burst_beats <= burst_calc;
            if (state == CMD) beat_cnt <= '0;
            if (beat_hs) beat_cnt <= beat_cnt + 9'd1;
            if (beat_hs && last_beat) remaining <= remaining - 32'(burst_beats);
        end
    end

    always_comb begin
        xfer_busy     = state inside {WAIT, REQ, CMD, DATA};
        xfer_done     = state == DONE;
        drain_req     = state == REQ;
        drain_size    = (state == REQ) ? burst_beats[7:0] : 8'd0;
        m_burst_valid = state == CMD;
        m_burst_len   = (state == CMD) ? burst_m1[7:0] : 8'd0;
        m_wvalid      = (state == DATA) && sram_valid;
        sram_ready    = (state == DATA) && m_wready;
        m_wdata       = (state == DATA) ? sram_data : '0;
        m_wlast       = (state == DATA) && last_beat;
    end

endmodule

// File: tb/tb_sram_drain_burst_reader.sv
// tb_sram_drain_burst_reader: randomized handshakes checked against a burst-splitting reference model
module tb_sram_drain_burst_reader;

    localparam int DW = 32, DEPTH = 64, SCW = 7, MB = 16;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [7:0]    cfg_burst_len = '0;
    logic          xfer_start = 1'b0;
    logic [31:0]   xfer_beats = '0;
    logic          xfer_busy, xfer_done;
    logic [SCW-1:0] drain_data_avail = '0;
    logic          drain_req;
    logic [7:0]    drain_size;
    logic          sram_valid = 1'b0, sram_ready;
    logic [DW-1:0] sram_data = '0;
    logic          m_burst_valid, m_burst_ready = 1'b0;
    logic [7:0]    m_burst_len;
    logic          m_wvalid, m_wready = 1'b0;
    logic [DW-1:0] m_wdata;
    logic          m_wlast;

    sram_drain_burst_reader #(.DATA_WIDTH(DW), .SRAM_DEPTH(DEPTH), .SEG_COUNT_WIDTH(SCW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_burst_len(cfg_burst_len), .xfer_start(xfer_start),
        .xfer_beats(xfer_beats), .xfer_busy(xfer_busy), .xfer_done(xfer_done),
        .drain_data_avail(drain_data_avail), .drain_req(drain_req), .drain_size(drain_size),
        .sram_valid(sram_valid), .sram_ready(sram_ready), .sram_data(sram_data),
        .m_burst_valid(m_burst_valid), .m_burst_ready(m_burst_ready), .m_burst_len(m_burst_len),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int p_valid = 100, p_wready = 100, p_bready = 100;
    int avail_knob = 64, start_knob = 0, rst_knob = 1, cfg_knob = 16;
    logic [31:0] beats_knob = '0;
    logic [31:0] word = '0, base;
    int prev_avail = 0, cur_beats = 0, done_cnt = 0, avail_bad = 0, ready_bad = 0, wvalid_seen = 0;
    int sizes_q[$], lens_q[$], bursts_q[$];
    logic [31:0] data_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are observed 1ns later and acted on at the next rising edge
    task automatic step();
        @(negedge clk);
        rst_n            = rst_knob[0];
        xfer_start       = start_knob[0];
        xfer_beats       = beats_knob;
        cfg_burst_len    = cfg_knob[7:0];
        drain_data_avail = SCW'(avail_knob);
        sram_valid       = $urandom_range(99) < p_valid;
        m_wready         = $urandom_range(99) < p_wready;
        m_burst_ready    = $urandom_range(99) < p_bready;
        sram_data        = word;
        #1;
        if (drain_req) begin
            sizes_q.push_back(int'(drain_size));
            if (prev_avail < int'(drain_size)) avail_bad++;
        end
        prev_avail = int'(drain_data_avail);
        if (m_burst_valid && m_burst_ready) lens_q.push_back(int'(m_burst_len));
        if (sram_ready && !m_wready) ready_bad++;
        if (m_wvalid) wvalid_seen++;
        if (m_wvalid && m_wready) begin
            data_q.push_back(m_wdata);
            cur_beats++;
            if (m_wlast) begin
                bursts_q.push_back(cur_beats);
                cur_beats = 0;
            end
        end
        if (sram_valid && sram_ready) word++;
        if (xfer_done) done_cnt++;
    endtask

    task automatic start_xfer(input int beats, input int cfg);
        sizes_q.delete(); lens_q.delete(); bursts_q.delete(); data_q.delete();
        cur_beats = 0; done_cnt = 0; wvalid_seen = 0; avail_bad = 0; ready_bad = 0;
        base = word;
        cfg_knob = cfg; beats_knob = 32'(beats); start_knob = 1;
        step();
        start_knob = 0;
    endtask

    task automatic finish_xfer(input string tag, input int beats, input int cfg);
        int n = 0, rem, c, b;
        int exp_q[$];
        while (done_cnt == 0 && n < 3000) begin step(); n++; end
        chk({tag, " done_seen"}, 64'(done_cnt), 64'd1);
        repeat (3) step();
        chk({tag, " done_once"}, 64'(done_cnt), 64'd1);
        chk({tag, " idle_busy"}, 64'(xfer_busy), 64'd0);
        rem = beats;
        c = (cfg == 0) ? 1 : (cfg > MB) ? MB : cfg;
        while (rem > 0) begin
            b = (rem < c) ? rem : c;
            exp_q.push_back(b);
            rem -= b;
        end
        chk({tag, " n_reqs"}, 64'(sizes_q.size()), 64'(exp_q.size()));
        chk({tag, " n_cmds"}, 64'(lens_q.size()), 64'(exp_q.size()));
        chk({tag, " n_bursts"}, 64'(bursts_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < sizes_q.size()) chk({tag, " drain_size"}, 64'(sizes_q[i]), 64'(exp_q[i]));
            if (i < lens_q.size()) chk({tag, " burst_len"}, 64'(lens_q[i]), 64'(exp_q[i] - 1));
            if (i < bursts_q.size()) chk({tag, " wlast_pos"}, 64'(bursts_q[i]), 64'(exp_q[i]));
        end
        chk({tag, " n_beats"}, 64'(data_q.size()), 64'(beats));
        for (int i = 0; i < data_q.size(); i++) chk({tag, " wdata"}, 64'(data_q[i]), 64'(base + 32'(i)));
        chk({tag, " avail_rule"}, 64'(avail_bad), 64'd0);
        chk({tag, " ready_rule"}, 64'(ready_bad), 64'd0);
    endtask

    initial begin
        rst_knob = 0;
        repeat (2) step();
        rst_knob = 1;
        step();
        chk("reset outs", {xfer_busy, xfer_done, drain_req, drain_size, sram_ready, m_burst_valid, m_burst_len, m_wvalid, m_wlast},
            '0);
        chk("reset wdata", 64'(m_wdata), 64'd0);

        // 40 beats in 16-beat bursts, with stray starts while busy
        start_xfer(40, 16);
        step();
        chk("t1 busy", 64'(xfer_busy), 64'd1);
        start_knob = 1; beats_knob = 5;
        repeat (3) step();
        start_knob = 0;
        finish_xfer("t1", 40, 16);

        // availability ramp gates the reservation
        avail_knob = 0;
        start_xfer(16, 16);
        for (int a = 0; a < 16; a++) begin avail_knob = a; step(); end
        chk("t2 no_req_below", 64'(sizes_q.size()), 64'd0);
        avail_knob = 16;
        step(); step();
        chk("t2 req_at_16", 64'(sizes_q.size()), 64'd1);
        finish_xfer("t2", 16, 16);
        avail_knob = 64;

        // throttled sink and gappy source
        p_valid = 70; p_wready = 50; p_bready = 60;
        start_xfer(16, 16);
        finish_xfer("t3", 16, 16);
        p_valid = 100; p_wready = 100; p_bready = 100;

        start_xfer(0, 16);
        finish_xfer("t4", 0, 16);
        chk("t4 no_wvalid", 64'(wvalid_seen), 64'd0);

        start_xfer(3, 0);
        finish_xfer("t5a", 3, 0);
        start_xfer(20, 200);
        finish_xfer("t5b", 20, 200);

        // reset in the middle of a burst
        start_xfer(16, 16);
        for (int n = 0; n < 200 && data_q.size() < 5; n++) step();
        rst_knob = 0;
        step();
        rst_knob = 1;
        step();
        chk("t6 outs_after_rst", {xfer_busy, xfer_done, drain_req, sram_ready, m_burst_valid, m_wvalid, m_wlast}, '0);
        repeat (4) step();
        chk("t6 no_done", 64'(done_cnt), 64'd0);
        start_xfer(16, 16);
        finish_xfer("t6", 16, 16);

        for (int t = 0; t < 10; t++) begin
            int nb, cf;
            nb = $urandom_range(50);
            cf = $urandom_range(40);
            p_valid = $urandom_range(100, 30); p_wready = $urandom_range(100, 30); p_bready = $urandom_range(100, 30);
            start_xfer(nb, cf);
            finish_xfer("rand", nb, cf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
